pipeline_hazard_ctrl: RTL

//  Sequencer for the 5-stage MIPS pipeline. The pipeline has no forwarding paths.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 50 +++++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard sequencer.
// Contents: instruction opcodes, FSM state encoding, register address width,
//           the scoreboard entry type and its source-compare helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    // Primary opcodes (IR[31:26]) of the supported instruction subset.
    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_J    = 6'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // One in-flight register writer.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    // True when a valid in-flight writer targets a source the ID instruction reads.
    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic src_match(
        input sb_entry_t         e,
        input logic              use_src,
        input logic [REG_AW-1:0] src
    );
        return e.v & use_src & (e.rd == src) & (src != '0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: shift register of in-flight writers (EX, MEM, WB) plus the
// RAW compare against the ID-stage sources.
// Ports: clk/rst, ID source fields in, write request (wr_en/wr_rd) in, hazard out.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_rd,
    output logic              hazard
);

    sb_entry_t sb [DEPTH];

    // The shift runs every cycle, including stall cycles: this is what lets a
    // stall drain on its own within DEPTH cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '{v: wr_en, rd: wr_rd};
            for (int i = 1; i < DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // The WB entry is still compared: the register file returns the old value
    // when a write and a read hit the same edge.
    logic hit;
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | src_match(sb[i], id_use_rs, id_rs)
                      | src_match(sb[i], id_use_rt, id_rt);
        end
        hazard = id_valid & hit;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage MIPS pipeline without
// forwarding. Stalls PC and IF/ID on a pending source, bubbles ID/EX, flushes on redirect.
// Ports: clk, rst (sync, active high), ID-stage decode fields, ex_redirect in;
//        pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt out.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH          = 3,
    parameter int REDIRECT_SLOTS = 1,   // legal range 1..4
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              ex_redirect,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int             RC_W       = 3;
    localparam logic [RC_W-1:0] RC_LOAD   = RC_W'(REDIRECT_SLOTS - 1);
    localparam logic           MULTI_SLOT = (REDIRECT_SLOTS > 1);

    state_t          state, state_nxt;
    logic [RC_W-1:0] rc, rc_nxt;

    logic hazard;
    logic redirect_active;   // this cycle is a flush cycle
    logic redirect_accept;   // ex_redirect taken (not while already redirecting)
    logic stall_cycle;       // hazard stall that is not overridden by a flush
    logic issue;
    logic wr_en;

    assign issue = id_valid & ~hazard & ~redirect_active;
    assign wr_en = issue & id_regwrite & (id_rd != '0);

    hazard_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .wr_en     (wr_en),
        .wr_rd     (id_rd),
        .hazard    (hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            rc        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            rc    <= rc_nxt;
            if (stall_cycle && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect_accept && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        rc_nxt          = rc;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_bubble     = 1'b0;
        redirect_active = 1'b0;
        redirect_accept = 1'b0;
        stall_cycle     = 1'b0;

        case (state)
            ST_REDIRECT: begin
                // A bubble in EX cannot redirect, so ex_redirect is ignored here.
                redirect_active = 1'b1;
                ifid_flush      = 1'b1;
                idex_bubble     = 1'b1;
                rc_nxt          = rc - 1'b1;
                if (rc <= 1) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                if (ex_redirect) begin
                    // Redirect wins over a stall: the stalled instruction is wrong-path.
                    redirect_accept = 1'b1;
                    redirect_active = 1'b1;
                    ifid_flush      = 1'b1;
                    idex_bubble     = 1'b1;
                    rc_nxt          = RC_LOAD;
                    state_nxt       = MULTI_SLOT ? ST_REDIRECT : ST_RUN;
                end else if (hazard) begin
                    stall_cycle = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_nxt   = ST_HAZARD;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
        endcase

        // Hold the front end and keep NOPs flowing while reset is asserted.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

endmodule
